// File: rtl/full_adder_pkg.sv
// Shared constants and the 1-bit full-adder equation used by every adder cell.
package full_adder_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 8;

    // Returns {carry_out, sum} for one bit position.
    function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One ripple-carry cell; the top chains WIDTH of these through the carry.
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign {o_cout, o_sum} = fa_bit(i_a, i_b, i_cin);

endmodule

// File: rtl/full_adder_unit.sv
// Ripple-carry adder with a registered copy, an all-ones event flag and a
// saturating all-ones event counter.
module full_adder_unit
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid,
    output logic             all_ones,
    output logic [CNT_W-1:0] all_ones_cnt
);

    logic [WIDTH:0]   w_carry;
    logic             w_hit;

    logic [WIDTH-1:0] r_sum_q;
    logic             r_cout_q;
    logic             r_out_valid;
    logic             r_all_ones;
    logic [CNT_W-1:0] r_cnt;

    assign w_carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        full_adder_bit u_bit (
            .i_a    (a[gi]),
            .i_b    (b[gi]),
            .i_cin  (w_carry[gi]),
            .o_sum  (sum[gi]),
            .o_cout (w_carry[gi+1])
        );
    end

    assign cout  = w_carry[WIDTH];
    assign w_hit = in_valid & (&a) & (&b) & cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q     <= '0;
            r_cout_q    <= 1'b0;
            r_out_valid <= 1'b0;
            r_all_ones  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= in_valid;
            r_all_ones  <= w_hit;
            if (in_valid) begin
                r_sum_q  <= sum;
                r_cout_q <= cout;
            end
            // Counter sticks at all-ones rather than wrapping.
            if (w_hit && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sum_q        = r_sum_q;
    assign cout_q       = r_cout_q;
    assign out_valid    = r_out_valid;
    assign all_ones     = r_all_ones;
    assign all_ones_cnt = r_cnt;

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench: WIDTH=1 exhaustive, WIDTH=8 random against a+b+cin,
// and a CNT_W=2 instance for counter saturation.
module tb_full_adder_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // WIDTH=1 instance
    logic       v1, a1, b1, c1;
    logic       s1, co1, sq1, coq1, ov1, ao1;
    logic [7:0] cnt1;
    full_adder_unit #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .sum_q(sq1), .cout_q(coq1), .out_valid(ov1),
        .all_ones(ao1), .all_ones_cnt(cnt1)
    );

    // WIDTH=8 instance
    logic       v8, c8;
    logic [7:0] a8, b8, s8, sq8;
    logic       co8, coq8, ov8, ao8;
    logic [7:0] cnt8;
    full_adder_unit #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .sum(s8), .cout(co8), .sum_q(sq8), .cout_q(coq8), .out_valid(ov8),
        .all_ones(ao8), .all_ones_cnt(cnt8)
    );

    // WIDTH=4, CNT_W=2 instance
    logic       v4, c4;
    logic [3:0] a4, b4, s4, sq4;
    logic       co4, coq4, ov4, ao4;
    logic [1:0] cnt4;
    full_adder_unit #(.WIDTH(4), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
        .sum(s4), .cout(co4), .sum_q(sq4), .cout_q(coq4), .out_valid(ov4),
        .all_ones(ao4), .all_ones_cnt(cnt4)
    );

    a_all_ones: assert property (@(posedge clk) disable iff (rst)
        ao1 |-> $past(v1 & a1 & b1 & c1));

    // Reference state for the WIDTH=8 instance
    logic [8:0] m_q;
    logic       m_vld, m_ao;
    int         m_cnt;

    task automatic model8_reset();
        m_q = '0; m_vld = 1'b0; m_ao = 1'b0; m_cnt = 0;
    endtask

    // Advance one clock on u_w8 and compare the reference against the registered outputs.
    task automatic step8(input string tag);
        logic hit;
        hit = v8 && (a8 == 8'hFF) && (b8 == 8'hFF) && c8;
        if (v8) m_q = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
        m_vld = v8;
        m_ao  = hit;
        if (hit && m_cnt < 255) m_cnt++;
        tick();
        chk({tag, "_sum_q"}, sq8, m_q[7:0]);
        chk({tag, "_cout_q"}, coq8, m_q[8]);
        chk({tag, "_ov"}, ov8, m_vld);
        chk({tag, "_ao"}, ao8, m_ao);
        chk({tag, "_cnt"}, cnt8, m_cnt);
    endtask

    initial begin
        logic [1:0] e1;
        logic [8:0] e8;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        v8 = 0; a8 = 0; b8 = 0; c8 = 0;
        v4 = 0; a4 = 0; b4 = 0; c4 = 0;
        model8_reset();
        #12;
        chk("rst_w1_regs", {sq1, coq1, ov1, ao1, cnt1}, '0);
        chk("rst_w8_regs", {sq8, coq8, ov8, ao8, cnt8}, '0);
        chk("rst_c2_regs", {sq4, coq4, ov4, ao4, cnt4}, '0);
        @(posedge clk); #1; rst = 0;

        // 1. WIDTH=1 exhaustive
        for (int v = 0; v < 8; v++) begin
            {a1, b1, c1} = 3'(v); v1 = 1;
            e1 = 2'(a1) + 2'(b1) + 2'(c1);
            #1;
            chk("w1_comb", {co1, s1}, e1);
            tick();
            chk("w1_reg", {coq1, sq1}, e1);
            chk("w1_ov", ov1, 1'b1);
            chk("w1_ao", ao1, (v == 7));
        end
        chk("w1_cnt_after_sweep", cnt1, 8'd1);
        v1 = 0;

        // 2. all_ones run starting from a cleared counter
        rst = 1; #1; rst = 0;
        {a1, b1, c1} = 3'b111; v1 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ao_run", ao1, 1'b1);
        end
        a1 = 0;
        tick();
        chk("ao_drop", ao1, 1'b0);
        chk("ao_cnt3", cnt1, 8'd3);
        v1 = 0;

        // 3. WIDTH=8 directed then random
        a8 = 8'hFF; b8 = 8'h01; c8 = 0; v8 = 1;
        #1;
        chk("w8_ff_01_sum", s8, 8'h00);
        chk("w8_ff_01_cout", co8, 1'b1);
        step8("w8_ff_01");
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(7) == 0) begin
                a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            end
            v8 = ($urandom_range(3) != 0);
            e8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
            #1;
            chk("w8_rand_comb", {co8, s8}, e8);
            step8("w8_rand");
        end

        // 4. invalid cycles hold the registered result
        for (int n = 0; n < 4; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); v8 = 0;
            step8("w8_hold");
        end

        // 5. async reset mid-cycle while out_valid is high
        a8 = 8'h7F; b8 = 8'h80; c8 = 1; v8 = 1;
        step8("w8_pre_rst");
        chk("w8_pre_rst_ov_high", ov8, 1'b1);
        #2;
        rst = 1;
        #1;
        chk("arst_regs", {sq8, coq8, ov8, ao8, cnt8}, '0);
        chk("arst_comb", {co8, s8}, 9'h100);
        model8_reset();
        v8 = 0;
        @(negedge clk); rst = 0;
        a8 = 8'h12; b8 = 8'h34; c8 = 0; v8 = 1;
        step8("w8_post_rst");
        v8 = 0;

        // 6. CNT_W=2 saturation
        a4 = 4'hF; b4 = 4'hF; c4 = 1; v4 = 1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("c2_sat", cnt4, (k > 3) ? 2'd3 : 2'(k));
        end
        chk("c2_reg", {coq4, sq4}, 5'h1F);
        v4 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
